// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DATA_W = 32;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Access size codes; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Both 2'b10 and 2'b11 are full-word accesses
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - sub-word load extend and store merge
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_rData,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merge
);

  logic w_sign_b;
  logic w_sign_h;

  // Extension bit is the sub-word MSB unless the load is unsigned
  assign w_sign_b = ~i_uns & i_rData[7];
  assign w_sign_h = ~i_uns & i_rData[15];

  // Load: memory always returns addr..addr+3, the access lives in the low lanes
  always_comb begin
    o_load = i_rData;
    case (i_size)
      SZ_BYTE: o_load = {{24{w_sign_b}}, i_rData[7:0]};
      SZ_HALF: o_load = {{16{w_sign_h}}, i_rData[15:0]};
      default: o_load = i_rData;
    endcase
  end

  // Store: keep the untouched upper bytes of the old word
  always_comb begin
    o_merge = i_data;
    case (i_size)
      SZ_BYTE: o_merge = {i_old[31:8], i_data[7:0]};
      SZ_HALF: o_merge = {i_old[31:16], i_data[15:0]};
      default: o_merge = i_data;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with sub-word access
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_P0_req,
  input  logic              i_P0_we,
  input  logic [1:0]        i_P0_size,
  input  logic              i_P0_uns,
  input  logic [DATA_W-1:0] i_P0_addr,
  input  logic [DATA_W-1:0] i_P0_wData,
  output logic              o_P0_gnt,
  output logic              o_P0_done,
  output logic [DATA_W-1:0] o_P0_rData,
  input  logic              i_P1_req,
  input  logic              i_P1_we,
  input  logic [1:0]        i_P1_size,
  input  logic              i_P1_uns,
  input  logic [DATA_W-1:0] i_P1_addr,
  input  logic [DATA_W-1:0] i_P1_wData,
  output logic              o_P1_gnt,
  output logic              o_P1_done,
  output logic [DATA_W-1:0] o_P1_rData,
  output logic              o_DMem_we,
  output logic [DATA_W-1:0] o_DMem_addr,
  output logic [DATA_W-1:0] o_DMem_wData,
  input  logic [DATA_W-1:0] i_DMem_rData
);

  state_t              r_state;
  logic                r_port;
  logic                r_last;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wData;
  logic [DATA_W-1:0]   r_old;
  logic [DATA_W-1:0]   r_P0_rData;
  logic [DATA_W-1:0]   r_P1_rData;

  logic                w_any;
  logic                w_pick1;
  logic                w_grant;
  logic                w_sel_we;
  logic [1:0]          w_sel_size;
  logic                w_sel_uns;
  logic [DATA_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wData;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_merge;

  // Port 1 wins when alone, or on a tie when round-robin favours it (port 0 served last)
  assign w_any   = i_P0_req | i_P1_req;
  assign w_pick1 = i_P1_req & (~i_P0_req | (RR_EN & ~r_last));
  assign w_grant = (r_state == IDLE) & w_any & ~rst;

  assign o_P0_gnt = w_grant & ~w_pick1;
  assign o_P1_gnt = w_grant &  w_pick1;

  assign w_sel_we    = w_pick1 ? i_P1_we    : i_P0_we;
  assign w_sel_size  = w_pick1 ? i_P1_size  : i_P0_size;
  assign w_sel_uns   = w_pick1 ? i_P1_uns   : i_P0_uns;
  assign w_sel_addr  = w_pick1 ? i_P1_addr  : i_P0_addr;
  assign w_sel_wData = w_pick1 ? i_P1_wData : i_P0_wData;

  dmem_lane_align u_align (
    .i_rData (i_DMem_rData),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_old   (r_old),
    .i_data  (r_wData),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  // Transaction sequencer: latch the winner, access, optional write-back, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_port     <= 1'b0;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wData    <= '0;
      r_old      <= '0;
      r_P0_rData <= '0;
      r_P1_rData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_port  <= w_pick1;
            r_we    <= w_sel_we;
            r_size  <= w_sel_size;
            r_uns   <= w_sel_uns;
            r_addr  <= w_sel_addr;
            r_wData <= w_sel_wData;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (!r_we) begin
            if (r_port) r_P1_rData <= w_load;
            else        r_P0_rData <= w_load;
            r_state <= RESP;
          end else if (is_word(r_size)) begin
            r_state <= RESP;
          end else begin
            r_old   <= i_DMem_rData;
            r_state <= RMW_WR;
          end
        end
        RMW_WR: begin
          r_state <= RESP;
        end
        RESP: begin
          r_last  <= r_port;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-side signals decode from the state so reset kills a write at once
  always_comb begin
    o_DMem_we    = 1'b0;
    o_DMem_addr  = '0;
    o_DMem_wData = '0;
    case (r_state)
      ACC: begin
        o_DMem_we    = r_we & is_word(r_size);
        o_DMem_addr  = r_addr;
        o_DMem_wData = r_wData;
      end
      RMW_WR: begin
        o_DMem_we    = 1'b1;
        o_DMem_addr  = r_addr;
        o_DMem_wData = w_merge;
      end
      default: begin
        o_DMem_we    = 1'b0;
        o_DMem_addr  = '0;
        o_DMem_wData = '0;
      end
    endcase
  end

  assign o_P0_done  = (r_state == RESP) & ~r_port;
  assign o_P1_done  = (r_state == RESP) &  r_port;
  assign o_P0_rData = r_P0_rData;
  assign o_P1_rData = r_P1_rData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_mem;

  logic        p0_req, p0_we, p0_uns;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wData;
  logic        p1_req, p1_we, p1_uns;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wData;

  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rData, p1_rData;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wData, dm_rData;

  logic        f0_req, f1_req;
  logic        f0_gnt, f0_done, f1_gnt, f1_done;
  logic [31:0] f0_rData, f1_rData;
  logic        fm_we;
  logic [31:0] fm_addr, fm_wData;
  logic [31:0] zero32 = 32'h0;

  logic [7:0]  mem [0:255];
  logic [7:0]  ra;

  int n_vec = 0;
  int n_err = 0;

  logic        we_log   [0:7];
  logic [31:0] addr_log [0:7];
  logic [31:0] wd_log   [0:7];

  always #5 clk = ~clk;

  dmem_arbiter #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .i_P0_req(p0_req), .i_P0_we(p0_we), .i_P0_size(p0_size), .i_P0_uns(p0_uns),
    .i_P0_addr(p0_addr), .i_P0_wData(p0_wData),
    .o_P0_gnt(p0_gnt), .o_P0_done(p0_done), .o_P0_rData(p0_rData),
    .i_P1_req(p1_req), .i_P1_we(p1_we), .i_P1_size(p1_size), .i_P1_uns(p1_uns),
    .i_P1_addr(p1_addr), .i_P1_wData(p1_wData),
    .o_P1_gnt(p1_gnt), .o_P1_done(p1_done), .o_P1_rData(p1_rData),
    .o_DMem_we(dm_we), .o_DMem_addr(dm_addr), .o_DMem_wData(dm_wData),
    .i_DMem_rData(dm_rData)
  );

  dmem_arbiter #(.RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .rst(rst),
    .i_P0_req(f0_req), .i_P0_we(1'b0), .i_P0_size(2'b10), .i_P0_uns(1'b0),
    .i_P0_addr(32'h10), .i_P0_wData(32'h0),
    .o_P0_gnt(f0_gnt), .o_P0_done(f0_done), .o_P0_rData(f0_rData),
    .i_P1_req(f1_req), .i_P1_we(1'b0), .i_P1_size(2'b10), .i_P1_uns(1'b0),
    .i_P1_addr(32'h14), .i_P1_wData(32'h0),
    .o_P1_gnt(f1_gnt), .o_P1_done(f1_done), .o_P1_rData(f1_rData),
    .o_DMem_we(fm_we), .o_DMem_addr(fm_addr), .o_DMem_wData(fm_wData),
    .i_DMem_rData(zero32)
  );

  // Byte memory: combinational 4-byte little-endian read, write on clock
  assign ra = dm_addr[7:0];
  assign dm_rData = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h80;
      mem[8'h11] <= 8'h7F;
      mem[8'h12] <= 8'h34;
      mem[8'h13] <= 8'h12;
    end else if (dm_we) begin
      mem[ra]         <= dm_wData[7:0];
      mem[ra + 8'd1]  <= dm_wData[15:8];
      mem[ra + 8'd2]  <= dm_wData[23:16];
      mem[ra + 8'd3]  <= dm_wData[31:24];
    end
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic log_cycle(input int c);
    we_log[c]   = dm_we;
    addr_log[c] = dm_addr;
    wd_log[c]   = dm_wData;
  endtask

  // One transaction; the request drops the cycle after gnt. Entered just after a posedge.
  task automatic xact(input bit port, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, output int dcyc);
    int  cyc;
    bit  got;
    for (int k = 0; k < 8; k++) begin
      we_log[k] = 1'b0; addr_log[k] = 32'h0; wd_log[k] = 32'h0;
    end
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_size = sz; p1_uns = uns; p1_addr = addr; p1_wData = wd;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_size = sz; p0_uns = uns; p0_addr = addr; p0_wData = wd;
    end
    #1;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (port ? p1_gnt : p0_gnt) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("gnt_seen", {31'h0, got}, 32'h1);
    log_cycle(0);
    @(posedge clk); #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    cyc  = 1;
    dcyc = -1;
    while (cyc < 8) begin
      log_cycle(cyc);
      if (port ? p1_done : p0_done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
  endtask

  int dc;
  int rr_q[$];
  int fp_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_mem = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_size = 2'b10; p0_uns = 1'b0; p0_addr = 32'h0; p0_wData = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b10; p1_uns = 1'b0; p1_addr = 32'h0; p1_wData = 32'h0;
    f0_req = 1'b0; f1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a request present
    chk("rst_p0_gnt",  {31'h0, p0_gnt},  32'h0);
    chk("rst_p1_gnt",  {31'h0, p1_gnt},  32'h0);
    chk("rst_p0_done", {31'h0, p0_done}, 32'h0);
    chk("rst_p1_done", {31'h0, p1_done}, 32'h0);
    chk("rst_p0_rd",   p0_rData, 32'h0);
    chk("rst_p1_rd",   p1_rData, 32'h0);
    chk("rst_we",      {31'h0, dm_we},   32'h0);
    chk("rst_addr",    dm_addr,  32'h0);
    chk("rst_wdata",   dm_wData, 32'h0);
    p0_req = 1'b0;
    rst = 1'b0; load_mem = 1'b0;
    @(posedge clk); #1;

    // Loads from the preloaded word
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, dc);
    chk("lw_data", p0_rData, 32'h12347F80);
    chk("lw_done_cyc", dc, 2);
    chk("lw_no_we", {31'h0, we_log[0] | we_log[1] | we_log[2]}, 32'h0);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, dc);
    chk("lb_data", p0_rData, 32'hFFFFFF80);
    xact(1'b0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, dc);
    chk("lbu_data", p0_rData, 32'h00000080);
    xact(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, dc);
    chk("lh10_data", p0_rData, 32'h00007F80);
    xact(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, dc);
    chk("lh12_data", p0_rData, 32'h00001234);

    // Byte store through read-modify-write on port 1
    xact(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'hAABBCCDD, dc);
    chk("sb_acc_we", {31'h0, we_log[1]}, 32'h0);
    chk("sb_rmw_we", {31'h0, we_log[2]}, 32'h1);
    chk("sb_rmw_addr", addr_log[2], 32'h10);
    chk("sb_rmw_wd", wd_log[2], 32'h12347FDD);
    chk("sb_done_cyc", dc, 3);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, dc);
    chk("sb_readback", p1_rData, 32'h12347FDD);
    chk("p0_rd_held", p0_rData, 32'h00001234);

    // Word store, request dropped after gnt
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, dc);
    chk("sw_c1_we", {31'h0, we_log[1]}, 32'h1);
    chk("sw_c1_addr", addr_log[1], 32'h20);
    chk("sw_c1_wd", wd_log[1], 32'hDEADBEEF);
    chk("sw_done_cyc", dc, 2);
    chk("sw_mem", word_at(8'h20), 32'hDEADBEEF);

    // Reset in the middle of a half-word read-modify-write
    p0_req = 1'b1; p0_we = 1'b1; p0_size = 2'b01; p0_uns = 1'b0; p0_addr = 32'h10; p0_wData = 32'h00005555;
    #1;
    chk("sh_gnt", {31'h0, p0_gnt}, 32'h1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    chk("sh_acc_we", {31'h0, dm_we}, 32'h0);
    @(posedge clk); #1;
    chk("sh_rmw_we", {31'h0, dm_we}, 32'h1);
    chk("sh_rmw_wd", dm_wData, 32'h12345555);
    rst = 1'b1;
    #1;
    chk("ab_we", {31'h0, dm_we}, 32'h0);
    chk("ab_addr", dm_addr, 32'h0);
    chk("ab_wdata", dm_wData, 32'h0);
    chk("ab_p0_rd", p0_rData, 32'h0);
    chk("ab_p1_rd", p1_rData, 32'h0);
    chk("ab_p0_done", {31'h0, p0_done}, 32'h0);
    @(posedge clk); #1;
    chk("ab_mem", word_at(8'h10), 32'h12347FDD);
    chk("ab_no_done", {31'h0, p0_done | p1_done}, 32'h0);
    rst = 1'b0;
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, dc);
    chk("post_rst_lw", p0_rData, 32'h12347FDD);
    chk("post_rst_done", dc, 2);

    // Arbitration with both ports held, round-robin and fixed-priority instances
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p0_we = 1'b0; p0_size = 2'b10; p0_addr = 32'h10;
    p1_we = 1'b0; p1_size = 2'b10; p1_addr = 32'h20;
    p0_req = 1'b1; p1_req = 1'b1; f0_req = 1'b1; f1_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (p0_gnt) rr_q.push_back(0);
      if (p1_gnt) rr_q.push_back(1);
      if (f0_gnt) fp_q.push_back(0);
      if (f1_gnt) fp_q.push_back(1);
      @(posedge clk); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0; f0_req = 1'b0; f1_req = 1'b0;
    chk("rr_count", (rr_q.size() >= 3) ? 32'h1 : 32'h0, 32'h1);
    chk("fp_count", (fp_q.size() >= 3) ? 32'h1 : 32'h0, 32'h1);
    if (rr_q.size() >= 3) begin
      chk("rr_g0", rr_q[0], 0);
      chk("rr_g1", rr_q[1], 1);
      chk("rr_g2", rr_q[2], 0);
    end
    if (fp_q.size() >= 3) begin
      chk("fp_g0", fp_q[0], 0);
      chk("fp_g1", fp_q[1], 0);
      chk("fp_g2", fp_q[2], 0);
    end
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
